prio_arb_sched: RTL and testbench

//  Clocked 4-requester priority arbiter/scheduler that grants one shared slave to one

---
 rtl/prio_arb_pkg.sv | 11 +
 rtl/prio_arb_pick.sv | 49 ++++
 rtl/prio_arb_sched.sv | 147 ++++++++++++++
 tb/tb_prio_arb_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_arb_pkg.sv
// Shared types and sizing for the 4-requester priority arbiter/scheduler.
package prio_arb_pkg;

    localparam int N_REQ_C  = 4;
    localparam int PRIO_W_C = 3;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_e;

    typedef logic [PRIO_W_C-1:0] prio_t;

endpackage

// File: rtl/prio_arb_pick.sv
// Combinational winner selection: highest effective priority among requesters,
// ties broken by the first requester found after rr_ptr.
module prio_arb_pick
    import prio_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_C,
    parameter int PRIO_W = PRIO_W_C,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*PRIO_W-1:0] eprio,
    input  logic [ID_W-1:0]         rr_ptr,
    output logic                    win_vld,
    output logic [ID_W-1:0]         win_id
);

    logic [PRIO_W-1:0] max_p;
    logic [N_REQ-1:0]  cand;

    always_comb begin
        max_p = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && (eprio[i*PRIO_W +: PRIO_W] > max_p)) begin
                max_p = eprio[i*PRIO_W +: PRIO_W];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            cand[i] = req[i] && (eprio[i*PRIO_W +: PRIO_W] == max_p);
        end
    end

    // Scan the candidates starting one past the last winner.
    always_comb begin
        logic            found;
        logic [ID_W-1:0] idx;
        found   = 1'b0;
        idx     = '0;
        win_id  = '0;
        win_vld = |req;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!found && cand[idx]) begin
                win_id = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_arb_sched.sv
// Priority arbiter/scheduler with full transaction hold, timeout and one dead cycle
// between grants. Optional priority aging is enabled by defining PRIO_AGING_EN.
module prio_arb_sched
    import prio_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_C,
    parameter int PRIO_W   = PRIO_W_C,
    parameter int MAX_HOLD = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*PRIO_W-1:0]   prio,
    input  logic [N_REQ-1:0]          done,
    output logic [N_REQ-1:0]          gnt,
    output logic                      gnt_vld,
    output logic [$clog2(N_REQ)-1:0]  gnt_id,
    output logic                      timeout
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD);

    arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    hold_cnt, hold_d;
    logic [ID_W-1:0]     rr_ptr, rr_d;
    logic [N_REQ-1:0]    gnt_d;
    logic [ID_W-1:0]     gnt_id_d;
    logic                timeout_d;
    logic [N_REQ*PRIO_W-1:0] eprio;
    logic                win_vld;
    logic [ID_W-1:0]     win_id;
    logic                cur_req, cur_done, hold_hit;

    assign cur_req  = req[gnt_id];
    assign cur_done = done[gnt_id];
    assign hold_hit = (hold_cnt == CNT_W'(MAX_HOLD - 1));

`ifdef PRIO_AGING_EN
    logic [N_REQ*PRIO_W-1:0] age;

    function automatic logic [PRIO_W-1:0] sat_add(input logic [PRIO_W-1:0] a,
                                                  input logic [PRIO_W-1:0] b);
        logic [PRIO_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[PRIO_W] ? '1 : s[PRIO_W-1:0];
    endfunction

    // Waiting requesters age; winning or dropping the request clears the age.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i] ||
                    (state_q == IDLE && win_vld && int'(win_id) == i) ||
                    (state_q == GRANT && int'(gnt_id) == i)) begin
                    age[i*PRIO_W +: PRIO_W] <= '0;
                end else if (state_q != RELEASE) begin
                    age[i*PRIO_W +: PRIO_W] <= sat_add(age[i*PRIO_W +: PRIO_W], PRIO_W'(1));
                end
            end
        end
    end

    always_comb begin
        eprio = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eprio[i*PRIO_W +: PRIO_W] = sat_add(prio[i*PRIO_W +: PRIO_W],
                                                age[i*PRIO_W +: PRIO_W]);
        end
    end
`else
    assign eprio = prio;
`endif

    prio_arb_pick #(
        .N_REQ  (N_REQ),
        .PRIO_W (PRIO_W)
    ) u_pick (
        .req     (req),
        .eprio   (eprio),
        .rr_ptr  (rr_ptr),
        .win_vld (win_vld),
        .win_id  (win_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hold_cnt <= '0;
            rr_ptr   <= ID_W'(N_REQ - 1);
            gnt      <= '0;
            gnt_vld  <= 1'b0;
            gnt_id   <= '0;
            timeout  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_cnt <= hold_d;
            rr_ptr   <= rr_d;
            gnt      <= gnt_d;
            gnt_vld  <= |gnt_d;
            gnt_id   <= gnt_id_d;
            timeout  <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_cnt;
        rr_d      = rr_ptr;
        gnt_d     = gnt;
        gnt_id_d  = gnt_id;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (win_vld) begin
                    state_d  = GRANT;
                    gnt_d    = N_REQ'(1) << win_id;
                    gnt_id_d = win_id;
                    hold_d   = '0;
                end
            end
            GRANT: begin
                // A completed transaction takes precedence over a timeout.
                if (cur_done || !cur_req || hold_hit) begin
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    timeout_d = hold_hit && !cur_done && cur_req;
                end else begin
                    hold_d = hold_cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
                gnt_d   = '0;
                rr_d    = gnt_id;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_prio_arb_sched.sv
// Scoreboard bench for prio_arb_sched: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_prio_arb_sched;

    localparam int MAX_HOLD = 16;

    typedef struct {
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] id;
        logic       to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] prio;
    logic [3:0]  done;
    logic [3:0]  gnt;
    logic        gnt_vld;
    logic [1:0]  gnt_id;
    logic        timeout;

    int ncmp = 0;
    int nbad = 0;
    exp_t sbq[$];

    // Reference model state: current owner (-1 none), grant cycles so far,
    // pending dead cycle, last winner, reported id and per-master ages.
    int m_owner, m_held, m_cool, m_last, m_id;
    int m_age[4];

    prio_arb_sched #(
        .N_REQ    (4),
        .PRIO_W   (3),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .prio    (prio),
        .done    (done),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] pk(input int p0, input int p1, input int p2, input int p3);
        return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    function automatic int sat7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    function automatic int eff(input int i, input logic [11:0] p);
        int v;
        v = int'(p[i*3 +: 3]);
`ifdef PRIO_AGING_EN
        v = sat7(v + m_age[i]);
`endif
        return v;
    endfunction

    task automatic m_reset();
        m_owner = -1;
        m_held  = 0;
        m_cool  = 0;
        m_last  = 3;
        m_id    = 0;
        for (int i = 0; i < 4; i++) m_age[i] = 0;
    endtask

    task automatic m_step(input logic [3:0] r, input logic [11:0] p, input logic [3:0] d,
                          output exp_t e);
        int w;
        e.to = 1'b0;
        if (m_owner >= 0) begin
            for (int i = 0; i < 4; i++) m_age[i] = (r[i] && i != m_owner) ? sat7(m_age[i] + 1) : 0;
            if (d[m_owner] || !r[m_owner] || m_held == MAX_HOLD) begin
                e.to    = (m_held == MAX_HOLD) && !d[m_owner] && r[m_owner];
                m_last  = m_owner;
                m_owner = -1;
                m_cool  = 1;
            end else begin
                m_held++;
            end
        end else if (m_cool > 0) begin
            m_cool = 0;
            for (int i = 0; i < 4; i++) if (!r[i]) m_age[i] = 0;
        end else begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                int j;
                j = (m_last + k) % 4;
                if (r[j] && (w < 0 || eff(j, p) > eff(w, p))) w = j;
            end
            for (int i = 0; i < 4; i++) m_age[i] = (r[i] && i != w) ? sat7(m_age[i] + 1) : 0;
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
                m_id    = w;
            end
        end
        e.gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        e.vld = (m_owner >= 0);
        e.id  = 2'(m_id);
    endtask

    task automatic cyc(input logic [3:0] r, input logic [11:0] p, input logic [3:0] d);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1;
        req   = r;
        prio  = p;
        done  = d;
        m_step(r, p, d, e);
        sbq.push_back(e);
    endtask

    task automatic look(input logic [3:0] eg, input logic eto, input string nm);
        @(posedge clk);
        #3;
        chk({nm, ".gnt"}, 32'(gnt), 32'(eg));
        chk({nm, ".timeout"}, 32'(timeout), 32'(eto));
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        m_reset();
        e.gnt = '0;
        e.vld = 1'b0;
        e.id  = '0;
        e.to  = 1'b0;
        #1;
        chk("rst.gnt", 32'(gnt), 32'(0));
        chk("rst.gnt_vld", 32'(gnt_vld), 32'(0));
        chk("rst.gnt_id", 32'(gnt_id), 32'(0));
        chk("rst.timeout", 32'(timeout), 32'(0));
        sbq.push_back(e);
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            sbq.push_back(e);
        end
    endtask

    // Monitor: every edge that has a pending expectation is checked.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb.gnt", 32'(gnt), 32'(e.gnt));
            chk("sb.gnt_vld", 32'(gnt_vld), 32'(e.vld));
            chk("sb.gnt_id", 32'(gnt_id), 32'(e.id));
            chk("sb.timeout", 32'(timeout), 32'(e.to));
        end
    end

    initial begin
        logic [3:0]  rq;
        logic [3:0]  dn;
        logic [11:0] pr;
        rst_n = 1'b1;
        req   = '0;
        prio  = '0;
        done  = '0;
        m_reset();
        #2 rst_n = 1'b0;
        do_reset(2);

        // T1: single requester, then done and dead cycle
        cyc(4'b0001, pk(2, 0, 0, 0), 4'b0000); look(4'b0001, 1'b0, "t1.grant");
        cyc(4'b0001, pk(2, 0, 0, 0), 4'b0001); look(4'b0000, 1'b0, "t1.release");
        cyc(4'b0000, pk(2, 0, 0, 0), 4'b0000); look(4'b0000, 1'b0, "t1.idle");

        // T2: highest priority, then round-robin among equals
        cyc(4'b1111, pk(1, 5, 5, 3), 4'b0000); look(4'b0010, 1'b0, "t2.first");
        cyc(4'b1111, pk(1, 5, 5, 3), 4'b0010); look(4'b0000, 1'b0, "t2.release");
        cyc(4'b1111, pk(1, 5, 5, 3), 4'b0000); look(4'b0000, 1'b0, "t2.idle");
        cyc(4'b1111, pk(1, 5, 5, 3), 4'b0000); look(4'b0100, 1'b0, "t2.rotate");
        cyc(4'b1111, pk(1, 5, 5, 3), 4'b0100);
        cyc(4'b0000, pk(1, 5, 5, 3), 4'b0000);

        // T3: held request with no done times out after MAX_HOLD cycles
        for (int k = 0; k < MAX_HOLD; k++) begin
            cyc(4'b1000, pk(0, 0, 0, 4), 4'b0000); look(4'b1000, 1'b0, "t3.hold");
        end
        cyc(4'b1000, pk(0, 0, 0, 4), 4'b0000); look(4'b0000, 1'b1, "t3.timeout");
        cyc(4'b1000, pk(0, 0, 0, 4), 4'b0000); look(4'b0000, 1'b0, "t3.idle");
        cyc(4'b1000, pk(0, 0, 0, 4), 4'b0000); look(4'b1000, 1'b0, "t3.regrant");
        cyc(4'b0000, pk(0, 0, 0, 4), 4'b0000);
        cyc(4'b0000, pk(0, 0, 0, 4), 4'b0000);

        // T4: no preemption by a higher-priority arrival
        cyc(4'b0001, pk(1, 0, 0, 0), 4'b0000); look(4'b0001, 1'b0, "t4.grant0");
        cyc(4'b0101, pk(1, 0, 7, 0), 4'b0000); look(4'b0001, 1'b0, "t4.nopreempt");
        cyc(4'b0101, pk(1, 0, 7, 0), 4'b0000); look(4'b0001, 1'b0, "t4.hold");
        cyc(4'b0101, pk(1, 0, 7, 0), 4'b0001); look(4'b0000, 1'b0, "t4.release");
        cyc(4'b0100, pk(1, 0, 7, 0), 4'b0000); look(4'b0000, 1'b0, "t4.idle");
        cyc(4'b0100, pk(1, 0, 7, 0), 4'b0000); look(4'b0100, 1'b0, "t4.grant2");
        cyc(4'b0000, pk(1, 0, 7, 0), 4'b0000);
        cyc(4'b0000, pk(1, 0, 7, 0), 4'b0000);

        // T5: reset mid-grant, then equal-priority tie goes to master 0
        cyc(4'b0010, pk(3, 3, 3, 3), 4'b0000); look(4'b0010, 1'b0, "t5.grant1");
        do_reset(2);
        cyc(4'b1111, pk(4, 4, 4, 4), 4'b0000); look(4'b0001, 1'b0, "t5.after_rst");
        cyc(4'b0000, pk(4, 4, 4, 4), 4'b0000);
        cyc(4'b0000, pk(4, 4, 4, 4), 4'b0000);

`ifdef PRIO_AGING_EN
        // T6: low-priority master ages until it wins
        for (int c = 0; c < 80; c++) begin
            dn = '0;
            if (m_owner >= 0 && m_held >= 2) dn[m_owner] = 1'b1;
            cyc(4'b0011, pk(0, 6, 0, 0), dn);
        end
        cyc(4'b0000, '0, '0);
        cyc(4'b0000, '0, '0);
`endif

        // Random traffic
        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!rq[i]) rq[i] = ($urandom_range(3, 0) == 0);
                else if ($urandom_range(39, 0) == 0) rq[i] = 1'b0;
            end
            dn = '0;
            if (m_owner >= 0 && $urandom_range(5, 0) == 0) dn[m_owner] = 1'b1;
            if ($urandom_range(9, 0) == 0) dn[$urandom_range(3, 0)] = 1'b1;
            pr = 12'($urandom);
            if ($urandom_range(599, 0) == 0) begin
                do_reset(2);
                rq = '0;
            end else begin
                cyc(rq, pr, dn);
            end
            for (int i = 0; i < 4; i++) if (dn[i] && $urandom_range(1, 0) == 1) rq[i] = 1'b0;
        end

        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
